// File: rtl/mult_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential multiplier controller.
// The master side issues operands and consumes products.
interface mult_seq_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] product;

   modport master (
      output in_valid,
      output multiplicand,
      output multiplier,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  product
   );

   modport slave (
      input  in_valid,
      input  multiplicand,
      input  multiplier,
      input  out_ready,
      output in_ready,
      output out_valid,
      output product
   );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Shift-add sequencer for a 32x32 unsigned multiply using an external adder.
// One add/shift iteration per clock; 32 iterations per product.
module mult_seq_ctrl (
   input  logic                 clk,
   input  logic                 rst,
   mult_seq_ctrl_if.slave       bus,
   output logic [31:0]          alu_src_1,
   output logic [31:0]          alu_src_2,
   output logic                 alu_addu_ctrl,
   input  logic                 alu_carry,
   input  logic [31:0]          alu_result
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] prod_q, prod_d;
   logic [31:0] mcand_q, mcand_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         prod_q  <= 64'd0;
         mcand_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         mcand_q <= mcand_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      prod_d        = prod_q;
      mcand_d       = mcand_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      alu_addu_ctrl = 1'b0;
      case (state_q)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) begin
               prod_d  = {32'h0, bus.multiplier};
               mcand_d = bus.multiplicand;
               cnt_d   = 5'd0;
               state_d = CALC;
            end
         end
         CALC: begin
            // Carry becomes bit 63, so the full 64-bit product never overflows.
            alu_addu_ctrl = prod_q[0];
            prod_d        = {alu_carry, alu_result, prod_q[31:1]};
            cnt_d         = cnt_q + 5'd1;
            if (cnt_q == 5'd31)
               state_d = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign alu_src_1   = prod_q[63:32];
   assign alu_src_2   = mcand_q;
   assign bus.product = prod_q;

endmodule
